// File: rtl/systolic_feeder_2x2.sv
// Upstream sequencer for the 2x2 systolic array: weight load, skewed activation feed, drain, done.
// Optional bubble performance counter enabled by defining SF_PERF_CNT_EN.
module systolic_feeder_2x2 #(
  parameter int DATA_WIDTH = 16,
  parameter int A_ROWS     = 2,
  parameter int DRAIN_CYC  = 3
) (
  input  logic                  sf_clk,
  input  logic                  sf_rst,
  input  logic                  sf_start,
  input  logic                  sf_w_valid,
  output logic                  sf_w_ready,
  input  logic [DATA_WIDTH-1:0] sf_w_0,
  input  logic [DATA_WIDTH-1:0] sf_w_1,
  input  logic                  sf_a_valid,
  output logic                  sf_a_ready,
  input  logic [DATA_WIDTH-1:0] sf_a_0,
  input  logic [DATA_WIDTH-1:0] sf_a_1,
  output logic [DATA_WIDTH-1:0] sf_RD_0,
  output logic [DATA_WIDTH-1:0] sf_RD_1,
  output logic                  sf_load,
  output logic [DATA_WIDTH-1:0] sf_FDi_0,
  output logic [DATA_WIDTH-1:0] sf_FDi_1,
  output logic                  sf_busy,
`ifdef SF_PERF_CNT_EN
  output logic [15:0]           sf_bubble_cnt,
`endif
  output logic                  sf_done
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FEED, S_DRAIN, S_DONE} state_t;

  localparam logic [7:0] A_LAST = 8'(A_ROWS - 1);
  localparam logic [7:0] D_LAST = 8'(DRAIN_CYC - 1);

  state_t                state_q, state_d;
  logic                  w_cnt_q, w_cnt_d;
  logic [7:0]            a_cnt_q, a_cnt_d;
  logic [7:0]            d_cnt_q, d_cnt_d;
  logic [DATA_WIDTH-1:0] rd0_q, rd0_d, rd1_q, rd1_d;
  logic [DATA_WIDTH-1:0] fdi0_q, fdi0_d, fdi1_q, fdi1_d;
  logic [DATA_WIDTH-1:0] skew_q, skew_d;
  logic                  load_q, load_d;
  logic                  w_ready_q, w_ready_d;
  logic                  a_ready_q, a_ready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  w_hs, a_hs;
`ifdef SF_PERF_CNT_EN
  logic [15:0]           bub_q, bub_d;
`endif

  // Handshakes use the registered readies, i.e. what upstream saw this cycle.
  assign w_hs = sf_w_valid & w_ready_q;
  assign a_hs = sf_a_valid & a_ready_q;

  always_comb begin
    state_d = state_q;
    w_cnt_d = w_cnt_q;
    a_cnt_d = a_cnt_q;
    d_cnt_d = d_cnt_q;
    rd0_d   = rd0_q;
    rd1_d   = rd1_q;
    load_d  = 1'b0;
    fdi0_d  = '0;
    fdi1_d  = '0;
    skew_d  = '0;
`ifdef SF_PERF_CNT_EN
    bub_d   = bub_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (sf_start) begin
          state_d = S_LOAD;
          w_cnt_d = 1'b0;
          a_cnt_d = '0;
          d_cnt_d = '0;
`ifdef SF_PERF_CNT_EN
          bub_d   = '0;
`endif
        end
      end
      S_LOAD: begin
        if (w_hs) begin
          rd0_d  = sf_w_0;
          rd1_d  = sf_w_1;
          load_d = 1'b1;
          if (w_cnt_q) state_d = S_FEED;
          else         w_cnt_d = 1'b1;
        end
      end
      S_FEED: begin
        // Column 1 lags column 0 by one cycle through the skew register.
        fdi1_d = skew_q;
        if (a_hs) begin
          fdi0_d = sf_a_0;
          skew_d = sf_a_1;
          if (a_cnt_q == A_LAST) begin
            state_d = S_DRAIN;
            d_cnt_d = '0;
          end else begin
            a_cnt_d = a_cnt_q + 8'd1;
          end
        end
`ifdef SF_PERF_CNT_EN
        else if (bub_q != 16'hFFFF) begin
          bub_d = bub_q + 16'd1;
        end
`endif
      end
      S_DRAIN: begin
        fdi1_d = skew_q;
        if (d_cnt_q == D_LAST) begin
          state_d = S_DONE;
          fdi1_d  = '0;
        end else begin
          d_cnt_d = d_cnt_q + 8'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        rd0_d   = '0;
        rd1_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase
    w_ready_d = (state_d == S_LOAD);
    a_ready_d = (state_d == S_FEED);
    busy_d    = (state_d == S_LOAD) || (state_d == S_FEED) || (state_d == S_DRAIN);
    done_d    = (state_d == S_DONE);
  end

  always_ff @(posedge sf_clk) begin
    if (sf_rst) begin
      state_q   <= S_IDLE;
      w_cnt_q   <= 1'b0;
      a_cnt_q   <= '0;
      d_cnt_q   <= '0;
      rd0_q     <= '0;
      rd1_q     <= '0;
      fdi0_q    <= '0;
      fdi1_q    <= '0;
      skew_q    <= '0;
      load_q    <= 1'b0;
      w_ready_q <= 1'b0;
      a_ready_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef SF_PERF_CNT_EN
      bub_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      w_cnt_q   <= w_cnt_d;
      a_cnt_q   <= a_cnt_d;
      d_cnt_q   <= d_cnt_d;
      rd0_q     <= rd0_d;
      rd1_q     <= rd1_d;
      fdi0_q    <= fdi0_d;
      fdi1_q    <= fdi1_d;
      skew_q    <= skew_d;
      load_q    <= load_d;
      w_ready_q <= w_ready_d;
      a_ready_q <= a_ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef SF_PERF_CNT_EN
      bub_q     <= bub_d;
`endif
    end
  end

  assign sf_w_ready = w_ready_q;
  assign sf_a_ready = a_ready_q;
  assign sf_RD_0    = rd0_q;
  assign sf_RD_1    = rd1_q;
  assign sf_load    = load_q;
  assign sf_FDi_0   = fdi0_q;
  assign sf_FDi_1   = fdi1_q;
  assign sf_busy    = busy_q;
  assign sf_done    = done_q;
`ifdef SF_PERF_CNT_EN
  assign sf_bubble_cnt = bub_q;
`endif

endmodule

// File: tb/tb_systolic_feeder_2x2.sv
// Directed bench for systolic_feeder_2x2 (A_ROWS=2, DRAIN_CYC=3); outputs sampled 1ns after each rising edge.
module tb_systolic_feeder_2x2;
  localparam int DW = 16;

  logic          sf_clk, sf_rst, sf_start;
  logic          sf_w_valid, sf_w_ready, sf_a_valid, sf_a_ready;
  logic [DW-1:0] sf_w_0, sf_w_1, sf_a_0, sf_a_1;
  logic [DW-1:0] sf_RD_0, sf_RD_1, sf_FDi_0, sf_FDi_1;
  logic          sf_load, sf_busy, sf_done;
`ifdef SF_PERF_CNT_EN
  logic [15:0]   sf_bubble_cnt;
`endif

  int checks = 0;
  int errors = 0;

  systolic_feeder_2x2 #(.DATA_WIDTH(DW), .A_ROWS(2), .DRAIN_CYC(3)) dut (
    .sf_clk(sf_clk), .sf_rst(sf_rst), .sf_start(sf_start),
    .sf_w_valid(sf_w_valid), .sf_w_ready(sf_w_ready), .sf_w_0(sf_w_0), .sf_w_1(sf_w_1),
    .sf_a_valid(sf_a_valid), .sf_a_ready(sf_a_ready), .sf_a_0(sf_a_0), .sf_a_1(sf_a_1),
    .sf_RD_0(sf_RD_0), .sf_RD_1(sf_RD_1), .sf_load(sf_load),
    .sf_FDi_0(sf_FDi_0), .sf_FDi_1(sf_FDi_1), .sf_busy(sf_busy),
`ifdef SF_PERF_CNT_EN
    .sf_bubble_cnt(sf_bubble_cnt),
`endif
    .sf_done(sf_done)
  );

  initial sf_clk = 1'b0;
  always #5 sf_clk = ~sf_clk;

  task automatic tick();
    @(posedge sf_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Packs {busy, done, load, w_ready, a_ready} for compact control checks.
  function automatic logic [4:0] ctl();
    return {sf_busy, sf_done, sf_load, sf_w_ready, sf_a_ready};
  endfunction

  task automatic chk_data(input string tag, input int rd0, input int rd1, input int f0, input int f1);
    chk({tag, ".RD0"}, 32'(sf_RD_0), 32'(rd0));
    chk({tag, ".RD1"}, 32'(sf_RD_1), 32'(rd1));
    chk({tag, ".FDi0"}, 32'(sf_FDi_0), 32'(f0));
    chk({tag, ".FDi1"}, 32'(sf_FDi_1), 32'(f1));
  endtask

  initial begin
    int n;
    sf_rst = 1'b1; sf_start = 1'b1; sf_w_valid = 1'b1; sf_a_valid = 1'b1;
    sf_w_0 = 16'd9; sf_w_1 = 16'd9; sf_a_0 = 16'd9; sf_a_1 = 16'd9;

    // Reset held with start/valids high
    tick(); chk("rst1.ctl", 32'(ctl()), 32'h0); chk_data("rst1", 0, 0, 0, 0);
    tick(); chk("rst2.ctl", 32'(ctl()), 32'h0); chk_data("rst2", 0, 0, 0, 0);
    sf_rst = 1'b0; sf_start = 1'b0; sf_w_valid = 1'b0; sf_a_valid = 1'b0;
    tick(); chk("idle.ctl", 32'(ctl()), 32'h0);

    // Job 1: back-to-back weights and activations
    sf_start = 1'b1;
    tick(); chk("j1.load_entry", 32'(ctl()), 32'b10010); chk_data("j1.le", 0, 0, 0, 0);
    sf_start = 1'b0; sf_w_valid = 1'b1; sf_w_0 = 16'd3; sf_w_1 = 16'd5;
    tick(); chk("j1.w1.ctl", 32'(ctl()), 32'b10110); chk_data("j1.w1", 3, 5, 0, 0);
    sf_w_0 = 16'd7; sf_w_1 = 16'd11;
    tick(); chk("j1.w2.ctl", 32'(ctl()), 32'b10101); chk_data("j1.w2", 7, 11, 0, 0);
    sf_w_valid = 1'b0; sf_a_valid = 1'b1; sf_a_0 = 16'd1; sf_a_1 = 16'd2;
    tick(); chk("j1.a1.ctl", 32'(ctl()), 32'b10001); chk_data("j1.a1", 7, 11, 1, 0);
    sf_a_0 = 16'd4; sf_a_1 = 16'd6;
    tick(); chk("j1.a2.ctl", 32'(ctl()), 32'b10000); chk_data("j1.a2", 7, 11, 4, 2);
    sf_a_valid = 1'b0;
    tick(); chk("j1.d1.ctl", 32'(ctl()), 32'b10000); chk_data("j1.d1", 7, 11, 0, 6);
    tick(); chk("j1.d2.ctl", 32'(ctl()), 32'b10000); chk_data("j1.d2", 7, 11, 0, 0);
    sf_start = 1'b1;  // must be ignored in DONE
    tick(); chk("j1.done.ctl", 32'(ctl()), 32'b01000); chk_data("j1.done", 7, 11, 0, 0);
    tick(); chk("j1.idle.ctl", 32'(ctl()), 32'b00000); chk_data("j1.idle", 0, 0, 0, 0);

    // Job 2 (start still high, taken in IDLE): weight gap and activation bubble
    tick(); chk("j2.load_entry", 32'(ctl()), 32'b10010);
    sf_start = 1'b0; sf_w_valid = 1'b1; sf_w_0 = 16'd9; sf_w_1 = 16'd13;
    tick(); chk("j2.w1.ctl", 32'(ctl()), 32'b10110); chk_data("j2.w1", 9, 13, 0, 0);
    sf_w_valid = 1'b0; sf_w_0 = 16'hDEAD; sf_a_valid = 1'b1; sf_a_0 = 16'd77;
    tick(); chk("j2.wgap.ctl", 32'(ctl()), 32'b10010); chk_data("j2.wgap", 9, 13, 0, 0);
    sf_w_valid = 1'b1; sf_w_0 = 16'd2; sf_w_1 = 16'd8; sf_a_valid = 1'b0;
    tick(); chk("j2.w2.ctl", 32'(ctl()), 32'b10101); chk_data("j2.w2", 2, 8, 0, 0);
    sf_w_valid = 1'b0; sf_a_valid = 1'b1; sf_a_0 = 16'd1; sf_a_1 = 16'd2;
    tick(); chk_data("j2.a1", 2, 8, 1, 0);
    sf_a_valid = 1'b0; sf_a_0 = 16'hBEEF; sf_a_1 = 16'hBEEF;
    tick(); chk("j2.bub.ctl", 32'(ctl()), 32'b10001); chk_data("j2.bub", 2, 8, 0, 2);
    sf_a_valid = 1'b1; sf_a_0 = 16'd4; sf_a_1 = 16'd6;
    tick(); chk("j2.a2.ctl", 32'(ctl()), 32'b10000); chk_data("j2.a2", 2, 8, 4, 0);
    sf_a_valid = 1'b0;
    tick(); chk_data("j2.d1", 2, 8, 0, 6);
`ifdef SF_PERF_CNT_EN
    chk("j2.bubble_cnt", 32'(sf_bubble_cnt), 32'd1);
`endif
    tick(); chk("j2.d2.busy", 32'(sf_busy), 32'd1);
    tick(); chk("j2.done.ctl", 32'(ctl()), 32'b01000);
    tick(); chk("j2.idle.ctl", 32'(ctl()), 32'b00000);

    // Job 3: reset after first activation handshake
    sf_start = 1'b1;
    tick(); sf_start = 1'b0; sf_w_valid = 1'b1; sf_w_0 = 16'd1; sf_w_1 = 16'd1;
    tick(); tick();
    sf_w_valid = 1'b0; sf_a_valid = 1'b1; sf_a_0 = 16'd1; sf_a_1 = 16'd2;
    tick(); chk_data("j3.a1", 1, 1, 1, 0);
    sf_rst = 1'b1; sf_a_0 = 16'd4; sf_a_1 = 16'd6;
    tick(); chk("j3.rst.ctl", 32'(ctl()), 32'h0); chk_data("j3.rst", 0, 0, 0, 0);
    sf_rst = 1'b0; sf_a_valid = 1'b0;
    tick(); chk("j3.post.ctl", 32'(ctl()), 32'h0); chk_data("j3.post", 0, 0, 0, 0);

    // Job 4: full job after reset; wait for done with a cycle budget
    sf_start = 1'b1;
    tick(); chk("j4.load_entry", 32'(ctl()), 32'b10010);
    sf_start = 1'b0; sf_w_valid = 1'b1; sf_w_0 = 16'd21; sf_w_1 = 16'd22;
    tick(); sf_w_0 = 16'd23; sf_w_1 = 16'd24;
    tick(); chk_data("j4.w2", 23, 24, 0, 0);
    sf_w_valid = 1'b0; sf_a_valid = 1'b1; sf_a_0 = 16'd31; sf_a_1 = 16'd32;
    tick(); sf_a_0 = 16'd33; sf_a_1 = 16'd34;
    tick(); chk_data("j4.a2", 23, 24, 33, 32);
    sf_a_valid = 1'b0;
    n = 0;
    while (sf_done !== 1'b1 && n < 20) begin tick(); n++; end
    chk("j4.drain_len", 32'(n), 32'd3);
    chk("j4.done.ctl", 32'(ctl()), 32'b01000);
    tick(); chk("j4.idle.ctl", 32'(ctl()), 32'b00000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/systolic_feeder_2x2.md
Name: systolic_feeder_2x2

Overview:
- Upstream sequencer for the 2x2 systolic array.
- Accepts weight rows (B) and activation rows (A) over valid/ready handshakes.
- Drives the array's weight-load port (RD_0/RD_1 + load) for the load phase.
- Then streams activations with a one-cycle skew on column 1, zero-fills bubbles, drains the pipeline and pulses done.

Parameters:
- DATA_WIDTH, 16, width of every data word.
- A_ROWS, 2, activation rows fed per job; legal range 1..255; 8-bit row counter.
- DRAIN_CYC, 3, zero-fill cycles after the last A row (2*dim-1 for dim=2); legal range 1..255.

Ports:
- sf_clk  in  1  clock; all state updates on rising edge.
- sf_rst  in  1  synchronous, active-high reset.
- sf_start  in  1  job start; sampled only in IDLE.
- sf_w_valid  in  1  weight row valid.
- sf_w_ready  out  1  weight row accepted.
- sf_w_0, sf_w_1  in  DATA_WIDTH  weight row, columns 0/1.
- sf_a_valid  in  1  activation row valid.
- sf_a_ready  out  1  activation row accepted.
- sf_a_0, sf_a_1  in  DATA_WIDTH  activation row, columns 0/1.
- sf_RD_0, sf_RD_1  out  DATA_WIDTH  weight data to array.
- sf_load  out  1  array weight-load strobe.
- sf_FDi_0, sf_FDi_1  out  DATA_WIDTH  skewed activation data to array.
- sf_busy  out  1  high in LOAD/FEED/DRAIN.
- sf_done  out  1  one-cycle job-complete pulse.

Behaviour:
- Clock and reset: one clock, sf_clk. Reset sf_rst is synchronous and active-high.
- Reset values: all outputs 0, including RD, FDi, load, busy, done and both readies. The skew register and all counters clear. State = IDLE.
- Reset priority: reset wins over every other input on the same edge. Reset mid-job aborts with no partial done; outputs are 0 after that edge.
- All outputs are registered. A handshake is valid&ready sampled at an edge.
- FSM: IDLE -> LOAD -> FEED -> DRAIN -> DONE -> IDLE.
- IDLE:
  - Both readies 0, load 0; RD and FDi hold 0.
  - sf_start=1 -> LOAD; row counters cleared.
- LOAD:
  - sf_w_ready=1.
  - Weight handshake at edge k -> after edge k: RD_0/RD_1 = w_0/w_1 and load=1 for that cycle only.
  - Cycles without a handshake: load=0, RD holds its last value.
  - After the 2nd weight handshake -> FEED. sf_w_ready drops after that edge.
- FEED:
  - sf_a_ready=1.
  - Handshake at edge k: FDi_0 = a_0 after edge k; a_1 is captured in the skew register and appears on FDi_1 after edge k+1.
  - Non-handshake cycle: FDi_0=0 (bubble); the skew register still shifts, loading 0.
  - After the A_ROWS-th handshake -> DRAIN. sf_a_ready drops after that edge.
  - RD holds the loaded weights; load=0.
- DRAIN:
  - Readies 0.
  - FDi_0=0; FDi_1 emits the pending skew value on the first drain cycle, then 0.
  - Stays exactly DRAIN_CYC cycles, then -> DONE.
- DONE:
  - sf_done=1 for exactly one cycle, busy=0, FDi=0 -> IDLE.
- sf_busy=1 exactly when state is LOAD, FEED or DRAIN.
- sf_start outside IDLE is ignored. sf_start in the DONE cycle is also ignored; a new job needs start in IDLE.
- valid while ready=0 is not consumed. Data inputs are don't-care when valid=0.
- Data passes through unmodified: no arithmetic, widths preserved.

Optional Feature:
- Macro: SF_PERF_CNT_EN.
- When defined:
  - Adds output sf_bubble_cnt (16 bits).
  - Counts FEED-state cycles with no activation handshake.
  - Cleared on the edge that takes IDLE -> LOAD and on reset.
  - Saturates at 16'hFFFF; holds its value after the job.
- When undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: assert sf_rst 2 cycles with start/valids high -> all outputs 0, readies 0, state IDLE.
- Weight load: start, then back-to-back weight rows (3,5),(7,11) -> load high 2 consecutive cycles with RD=(3,5) then (7,11). Then load 0, RD holds (7,11), w_ready 0.
- Skewed feed: A_ROWS=2, rows (1,2),(4,6) back-to-back -> FDi_0 sequence 1,4,0; FDi_1 sequence 0,2,6,0, one cycle later than column 0.
- Bubble: a_valid low for one cycle between rows (1,2) and (4,6) -> FDi_0 = 1,0,4; FDi_1 = 0,2,0,6.
  - With SF_PERF_CNT_EN defined: sf_bubble_cnt=1.
- Completion: after the last A handshake, busy stays high for 3 DRAIN cycles, then sf_done=1 for exactly one cycle with busy=0, then IDLE. A second start runs a full job correctly.
- Mid-job reset: assert sf_rst after the first A handshake -> outputs 0 next cycle, no sf_done pulse, readies 0. A following start completes normally.
